// File: rtl/mac_seq_pkg.sv
// Shared constants and types for the MAC sequencer: phase codes, FSM encoding, widths.
package mac_seq_pkg;

    localparam int CNT_W  = 4;
    localparam int ADDR_W = 8;

    // Phase codes seen by the MAC datapath on State.
    localparam logic [1:0] PH_LOAD = 2'b00;
    localparam logic [1:0] PH_IDLE = 2'b01;
    localparam logic [1:0] PH_ACC  = 2'b10;
    localparam logic [1:0] PH_WB   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4
    } state_e;

    // Map FSM state to the phase code driven onto State.
    function automatic logic [1:0] phase_of(input state_e s);
        case (s)
            S_P0:    phase_of = PH_LOAD;
            S_P1:    phase_of = PH_IDLE;
            S_P2:    phase_of = PH_ACC;
            S_P3:    phase_of = PH_WB;
            default: phase_of = PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mac_sequencer_seq_counter.sv
// Term/equation/address counters with latched job dimensions and end-of-row/job flags.
// The coefficient address is a running counter, so no multiplier is needed.
module seq_counter
    import mac_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [CNT_W-1:0]  num_eq_i,
    input  logic [CNT_W-1:0]  num_terms_i,
    output logic [CNT_W-1:0]  term_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              first_term_o,
    output logic              last_term_o,
    output logic              last_eq_o
);

    logic [CNT_W-1:0]  num_eq_q, num_eq_d;
    logic [CNT_W-1:0]  num_terms_q, num_terms_d;
    logic [CNT_W-1:0]  term_q, term_d;
    logic [CNT_W-1:0]  eq_q, eq_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign term_o       = term_q;
    assign addr_o       = addr_q;
    assign first_term_o = (term_q == '0);
    assign last_term_o  = (term_q == num_terms_q);
    assign last_eq_o    = (eq_q == num_eq_q);

    // Next-state: load on accepted start, step on each writeback exit, clear after the final term.
    always_comb begin
        num_eq_d    = num_eq_q;
        num_terms_d = num_terms_q;
        term_d      = term_q;
        eq_d        = eq_q;
        addr_d      = addr_q;
        if (load_i) begin
            num_eq_d    = num_eq_i;
            num_terms_d = num_terms_i;
            term_d      = '0;
            eq_d        = '0;
            addr_d      = '0;
        end else if (advance_i) begin
            if (last_term_o && last_eq_o) begin
                // Job finished: clear so the 16x16 case never shows a wrapped address.
                term_d = '0;
                eq_d   = '0;
                addr_d = '0;
            end else if (last_term_o) begin
                term_d = '0;
                eq_d   = eq_q + 4'd1;
                addr_d = addr_q + 8'd1;
            end else begin
                term_d = term_q + 4'd1;
                addr_d = addr_q + 8'd1;
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            num_eq_q    <= '0;
            num_terms_q <= '0;
            term_q      <= '0;
            eq_q        <= '0;
            addr_q      <= '0;
        end else begin
            num_eq_q    <= num_eq_d;
            num_terms_q <= num_terms_d;
            term_q      <= term_d;
            eq_q        <= eq_d;
            addr_q      <= addr_d;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Matrix-vector MAC sequencer: walks every (equation, term) pair through a
// four-phase load/wait/accumulate/writeback pass and pulses Done at the end.
module mac_sequencer
    import mac_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  num_eq_i,
    input  logic [CNT_W-1:0]  num_terms_i,
    input  logic              hold_i,
    output logic [1:0]        state_o,
    output logic [1:0]        control_o,
    output logic [ADDR_W-1:0] const_addr_o,
    output logic [CNT_W-1:0]  var_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    state_e state_q, state_d;
    logic   done_q, done_d;

    logic              load, advance;
    logic              first_term, last_term, last_eq;
    logic [CNT_W-1:0]  term;
    logic [ADDR_W-1:0] addr;

    // Start is only honoured from IDLE, so latched counts are stable mid-job.
    assign load    = (state_q == S_IDLE) && start_i;
    assign advance = (state_q == S_P3);

    seq_counter u_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (load),
        .advance_i    (advance),
        .num_eq_i     (num_eq_i),
        .num_terms_i  (num_terms_i),
        .term_o       (term),
        .addr_o       (addr),
        .first_term_o (first_term),
        .last_term_o  (last_term),
        .last_eq_o    (last_eq)
    );

    // Next-state logic; Hold stalls only the load phase.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_P0;
            S_P0:   if (!hold_i) state_d = S_P1;
            S_P1:   state_d = S_P2;
            S_P2:   state_d = S_P3;
            S_P3: begin
                if (last_term && last_eq) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_P0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and Done registers; reset wins over Start and Hold.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Outputs: control flags only in the load phase, addresses forced to 0 when idle.
    always_comb begin
        busy_o       = (state_q != S_IDLE);
        state_o      = phase_of(state_q);
        control_o    = (state_q == S_P0) ? {first_term, last_term} : 2'b00;
        const_addr_o = busy_o ? addr : '0;
        var_addr_o   = busy_o ? term : '0;
        done_o       = done_q;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Clock  input  1  single rising-edge clock for all state.
REQ-002 Reset  input  1  synchronous, active-low; sampled on rising Clock edge.
REQ-003 Start  input  1  one-cycle request to run a matrix-vector job; honoured only in IDLE.
REQ-004 NumEquations  input  4  equation count minus 1 (0 = 1 equation, 15 = 16); latched on accepted Start.
REQ-005 NumTerms  input  4  terms per equation minus 1 (0 = 1 term, 15 = 16); latched on accepted Start.
REQ-006 Hold  input  1  stall request; sampled only in phase P0.
REQ-007 State  output  2  MAC phase code: 00 load, 01 idle/wait, 10 accumulate, 11 writeback.
REQ-008 Control  output  2  [1] = first term of equation (clear accumulator), [0] = last term of equation.
REQ-009 ConstAddress  output  8  coefficient memory address; asynchronous-read memory, data valid in the same cycle.
REQ-010 VarAddress  output  4  variable memory address = current term index.
REQ-011 Busy  output  1  job in progress.
REQ-012 Done  output  1  one-cycle pulse at job completion.

Function
REQ-013 FSM states: IDLE, P0, P1, P2, P3; each term takes one P0-P1-P2-P3 pass; State = 00/01/10/11 in P0/P1/P2/P3.
REQ-014 In IDLE: State = 01, Control = 00, addresses = 0, Busy = 0; the MAC never sees 00 with Control[1] = 1 outside a job.
REQ-015 Start = 1 in IDLE: latch NumEquations/NumTerms, clear counters, enter P0 next cycle; Busy = 1 from that cycle.
REQ-016 Start while Busy is ignored; latched counts do not change mid-job.
REQ-017 Control[1] = 1 throughout P0 iff term index = 0; Control[0] = 1 throughout P0 iff term index = NumTerms; both = 1 when NumTerms = 0.
REQ-018 Control = 00 in P1-P3.
REQ-019 Hold = 1 in P0: remain in P0 with outputs unchanged; Hold is ignored in P1-P3.
REQ-020 In P3: if term index < NumTerms, increment term index; otherwise clear term index and increment equation index; ConstAddress increments by 1 on every P3 exit.
REQ-021 ConstAddress = equation index * (NumTerms + 1) + term index, maintained as a running counter without a multiplier; VarAddress = term index.
REQ-022 Leaving P3 of the last term of equation NumEquations: enter IDLE and assert Done for that one cycle, with Busy = 0.
REQ-023 Job length without Hold = 4 * (NumEquations + 1) * (NumTerms + 1) cycles of Busy.
REQ-024 Maximum job (15, 15): ConstAddress reaches 255 and does not wrap before Done.

Reset
REQ-025 Reset = 0 at a rising edge: FSM to IDLE, counters and latched counts to 0, Done = 0, Busy = 0, State = 01, Control = 00, on the same edge, including mid-job.
REQ-026 Reset overrides Start and Hold on the same edge.

Structure
REQ-027 The shared package holds the phase-code constants (00/01/10/11), the FSM state encoding, and the count and address widths (4, 8).
REQ-028 One sub-module, seq_counter, holds the term/equation/address counters and the last-term and last-equation flags; the FSM stays in the top module.

Verification
REQ-029 Job E=0, T=0: Start -> State 00,01,10,11 with Control = 11 in P0, ConstAddress = 0; Done on cycle 5; Busy for 4 cycles.
REQ-030 Job E=1, T=2 with the MAC model attached: ConstAddress 0..5, VarAddress 0,1,2,0,1,2; Control[1] set on terms 0 and 3; Control[0] set on terms 2 and 5; exactly 2 MAC writebacks with correct dot products; 24 Busy cycles.
REQ-031 Hold = 1 for 3 cycles in P0 of term 1 (E=0, T=1): P0 extends to 4 cycles with outputs unchanged; Busy lasts 11 cycles.
REQ-032 Start pulsed mid-job with different counts: no effect on the sequence or the cycle count.
REQ-033 Reset = 0 during P2 of term 3 (E=3, T=3): next cycle IDLE, State 01, Control 00, ConstAddress 0, no Done; a fresh Start then runs a full job.
REQ-034 Job E=15, T=15: final ConstAddress 255, 1024 Busy cycles, one Done pulse.
